// File: rtl/alu_pkg.sv
// Shared encodings for the serial arithmetic datapath.
package alu_pkg;

    // Sequencer states of the bit-serial unit.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operation select, as presented on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule : full_adder

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full_adder cell, LSB first,
// one bit per clock, with result/carry/overflow/zero flags and a
// start/busy/done handshake.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    // Counter only needs to reach WIDTH-1 inside RUN; sized for WIDTH for headroom.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cin_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (cin_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // Next values of the operand/sum shifters and the bit counter for one RUN step.
    // The sum bit is written after the shift so the same code holds for WIDTH=1.
    always_comb begin
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_sum;
        cnt_d          = cnt_q + CW'(1);
        last_bit       = (cnt_q == CW'(WIDTH - 1));
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cin_q      <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= (sub == OP_SUB) ? ~op_b : op_b;
                        cin_q   <= sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    sum_q <= sum_d;
                    cin_q <= fa_cout;
                    cnt_q <= cnt_d;
                    if (last_bit) begin
                        // cin_q is the carry into the MSB during the last step.
                        result_q   <= sum_d;
                        carry_q    <= fa_cout;
                        overflow_q <= cin_q ^ fa_cout;
                        zero_q     <= (sum_d == '0);
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs straight to the ports.
    always_comb begin
        busy     = busy_q;
        done     = done_q;
        result   = result_q;
        carry    = carry_q;
        overflow = overflow_q;
        zero     = zero_q;
    end

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH=8.
module tb_serial_add_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

    int errors = 0;
    int checks = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one clock; returns at the negedge after it was sampled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count clocks (after the sampling edge) until done, bounded.
    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #1;
        checks++;
        if ({busy, done, result, carry, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carry, overflow, zero);
        end
        #11 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b result=%h, required 0 0 00", busy, done, result);
        end
    endtask

    task automatic test_add_basic();
        int lat = 0;
        int busy_cnt = 0;
        launch(8'h3C, 8'h05, 1'b0);
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == 4) begin
                checks++;
                if (result !== 8'h00) begin
                    errors++;
                    $display("FAIL no_partial_result: result=%h mid-operation, required 00", result);
                end
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL add_latency: %0d clocks, required 8", lat);
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL add_busy_cycles: %0d, required 8", busy_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL add_busy_at_done: busy=%b, required 0", busy);
        end
        checks++;
        if ({result, carry, overflow, zero} !== {8'h41, 3'b000}) begin
            errors++;
            $display("FAIL add_3C_05: result=%h c=%b v=%b z=%b, required 41 0 0 0", result, carry, overflow, zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 8'h41) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%b result=%h, required 0 41", done, result);
        end
    endtask

    task automatic test_flags();
        logic [W-1:0] va [5] = '{8'h7F, 8'hFF, 8'h05, 8'h00, 8'h80};
        logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h01};
        logic         vs [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [W-1:0] vr [5] = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h7F};
        logic [2:0]   vf [5] = '{3'b010, 3'b101, 3'b101, 3'b000, 3'b110}; // {carry, overflow, zero}
        for (int i = 0; i < 5; i++) begin
            int lat = 0;
            launch(va[i], vb[i], vs[i]);
            wait_done(lat);
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL flags_latency[%0d]: %0d clocks, required 8", i, lat);
            end
            checks++;
            if (result !== vr[i]) begin
                errors++;
                $display("FAIL flags_result[%0d]: result=%h, required %h", i, result, vr[i]);
            end
            checks++;
            if ({carry, overflow, zero} !== vf[i]) begin
                errors++;
                $display("FAIL flags_cvz[%0d]: cvz=%b, required %b", i, {carry, overflow, zero}, vf[i]);
            end
        end
    endtask

    // Leaves the bench at the negedge where done is high.
    task automatic test_ignore_start();
        int lat;
        launch(8'h10, 8'h20, 1'b0);
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        op_a  = 8'hAA;
        op_b  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        wait_done(lat);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL ignore_latency: %0d clocks, required 8", lat);
        end
        checks++;
        if (result !== 8'h30) begin
            errors++;
            $display("FAIL ignore_start_result: result=%h, required 30", result);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_done_cycle: done=%b, required 1", done);
        end
        op_a  = 8'h01;
        op_b  = 8'h01;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy, result} !== {2'b01, 8'h30}) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b result=%h, required 0 1 30", done, busy, result);
        end
        wait_done(lat);
        checks++;
        if (lat != 8 || result !== 8'h02) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d result=%h, required 8 02", lat, result);
        end
    endtask

    task automatic test_async_reset();
        int lat = 0;
        int stray = 0;
        launch(8'h80, 8'h01, 1'b1);
        wait_done(lat);
        lat = 0;
        launch(8'h3C, 8'h05, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, result, carry, overflow} !== {1'b1, 8'h7F, 2'b11}) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b result=%h c=%b v=%b, required 1 7F 1 1", busy, result, carry, overflow);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carry, overflow, zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abandoned_op: %0d cycles with done/busy set after reset, required 0", stray);
        end
        lat = 0;
        launch(8'h02, 8'h03, 1'b0);
        wait_done(lat);
        checks++;
        if (lat != 8 || {result, carry, overflow, zero} !== {8'h05, 3'b000}) begin
            errors++;
            $display("FAIL post_reset_op: lat=%0d result=%h cvz=%b, required 8 05 000",
                     lat, result, {carry, overflow, zero});
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_flags();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_add_sub
